captura_clave: RTL
==================

# captura_clave

Keypad capture block that assembles the 16-bit access PIN consumed by the gate access controller. It takes single-key strobes from the parking keypad, builds a 4-digit BCD PIN with delete and send keys, and presents it on `clave_ingresada` with a one-cycle `clave_lista` strobe. Capture is enabled only while a vehicle is present and is frozen while the controller signals lockout.

## Interface

- `TIMEOUT_CICLOS`, default 1000: idle cycles after the last accepted key before a partial PIN is discarded. Valid range is 1 or more.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `tecla_valida` input, 1 bit: key-pressed level; one press per rising edge.
- `tecla` input, 4 bits: key code, valid when `tecla_valida` = 1.
- `llegado_vehiculo` input, 1 bit: vehicle at gate; enables capture.
- `alarm_bloqueo` input, 1 bit: controller lockout; blocks capture.
- `clave_ingresada` output, 16 bits: last sent PIN. First digit is in [15:12], last digit in [3:0].
- `clave_lista` output, 1 bit: one-cycle pulse when `clave_ingresada` is updated.
- `digitos` output, 3 bits: number of digits in the buffer (0–4).
- `error_tecla` output, 1 bit: one-cycle pulse on a rejected key.
- `timeout_clave` output, 1 bit: one-cycle pulse when a partial buffer is discarded by timeout.

## Operation

**Key codes**
- 0x0–0x9: digit.
- 0xE: delete last digit.
- 0xF: send.
- 0xA–0xD: invalid.

**Edge detection**
- A key is accepted at a rising `clk` edge where `tecla_valida` = 1 and the registered previous `tecla_valida` = 0.
- Holding the key produces exactly one acceptance.

**States**
- ESPERA: the reset state.
- CAPTURA
- BLOQUEO

**Transitions**, evaluated every edge with priority top-down:
- `alarm_bloqueo` = 1 → BLOQUEO. Buffer cleared, `digitos` = 0, keys ignored with no error.
- BLOQUEO with `alarm_bloqueo` = 0 → CAPTURA if `llegado_vehiculo` = 1, else ESPERA.
- `llegado_vehiculo` = 0 → ESPERA. Buffer cleared; keys ignored with no error.
- ESPERA with `llegado_vehiculo` = 1 → CAPTURA.

**Key handling in CAPTURA**
- Digit with `digitos` < 4: buffer = {buffer[11:0], tecla}, `digitos` + 1.
- Digit with `digitos` = 4: rejected. `error_tecla` pulses; buffer unchanged.
- Delete with `digitos` > 0: buffer = buffer >> 4, `digitos` − 1.
- Delete with `digitos` = 0: no-op, no error.
- Send with `digitos` = 4: `clave_ingresada` ← buffer and `clave_lista` pulses. Buffer is cleared, `digitos` = 0, state stays CAPTURA.
- Send with `digitos` < 4: `error_tecla` pulses; buffer unchanged.
- Invalid code: `error_tecla` pulses.

**Timeout**
- An idle counter runs in CAPTURA while `digitos` > 0. It is cleared on every accepted key (including rejected ones) and whenever `digitos` = 0.
- When the counter reaches `TIMEOUT_CICLOS`:
  - buffer is cleared and `digitos` = 0;
  - `timeout_clave` pulses;
  - the counter is cleared.
- If a key is accepted on the same edge the timeout would fire, the key wins and no timeout occurs.
- Counter width is $clog2(TIMEOUT_CICLOS+1).

**Output holding**
- `clave_ingresada` holds its value through ESPERA, BLOQUEO, and timeouts.
- It changes only on a successful send or on reset.

## Timing

**Reset values** (on `reset` = 0, asynchronous):
- state = ESPERA
- buffer = 0x0000
- `clave_ingresada` = 0x0000
- `digitos` = 0
- `clave_lista`, `error_tecla`, `timeout_clave` = 0
- previous-`tecla_valida` register = 0, so a key held through reset release is not accepted.

**Latency**
- All outputs are registered.
- The effect of a key accepted at edge N (`digitos`, `clave_ingresada`, any pulse) is visible after edge N and lasts exactly one cycle for pulses.
- `clave_lista` and the new `clave_ingresada` are asserted in the same cycle.
- The ESPERA→CAPTURA transition takes one edge. A key accepted on the same edge that `llegado_vehiculo` first rises is ignored.

**Boundary conditions**
- Reset asserted mid-capture clears the partial PIN immediately, without waiting for a clock edge.
- The three pulse outputs are mutually exclusive in any cycle.

## Test plan

- **Send valid PIN.** Reset, `llegado_vehiculo` = 1, keys 1,2,3,4 then F, each a 1-cycle strobe. Expect `digitos` to step 1→4, then `clave_ingresada` = 0x1234 with `clave_lista` high for exactly one cycle and `digitos` = 0.
- **Delete and reject.** Keys 5,6,E,7,8,9 then F. Expect `clave_ingresada` = 0x5789. Then keys 1,F: `error_tecla` pulses once, `clave_ingresada` stays 0x5789 and `digitos` stays 1.
- **Overflow and held key.** Five digits 1,2,3,4,5: the 5th pulses `error_tecla`. Then hold `tecla_valida` for 10 cycles with key F. Expect exactly one `clave_lista` and `clave_ingresada` = 0x1234.
- **Timeout.** With `TIMEOUT_CICLOS` = 8, key 3, then idle. Expect `timeout_clave` pulsing 8 cycles after acceptance with `digitos` → 0. A key at cycle 7 instead restarts the count and no timeout occurs.
- **Lockout and vehicle departure.** Enter 2 digits, raise `alarm_bloqueo`. Expect `digitos` = 0 and keys ignored with no `error_tecla`. Drop `alarm_bloqueo` and `llegado_vehiculo`: state is ESPERA and keys are ignored. Assert `reset` low asynchronously between edges: all outputs go to zero immediately.

Source files
------------

// File: rtl/captura_clave.sv
// rtl/captura_clave.sv - keypad capture of a 4-digit BCD access PIN
//
// Purpose: turns single-key strobes from the parking keypad into a 16-bit
// BCD PIN. Digits shift in from the right, 0xE deletes the last digit and
// 0xF sends a complete PIN. Capture runs only while a vehicle is present and
// no lockout is signalled. A partial PIN is dropped after TIMEOUT_CICLOS
// idle cycles.
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous reset, active low
//   tecla_valida     key-pressed level, one press per rising edge
//   tecla[3:0]       key code (0-9 digit, E delete, F send, A-D invalid)
//   llegado_vehiculo vehicle at gate, enables capture
//   alarm_bloqueo    controller lockout, freezes capture
//   clave_ingresada  last sent PIN, first digit in [15:12]
//   clave_lista      one-cycle pulse when clave_ingresada updates
//   digitos[2:0]     digits currently held in the buffer (0-4)
//   error_tecla      one-cycle pulse on a rejected key
//   timeout_clave    one-cycle pulse when a partial PIN is discarded

module captura_clave #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla,
    input  logic        llegado_vehiculo,
    input  logic        alarm_bloqueo,
    output logic [15:0] clave_ingresada,
    output logic        clave_lista,
    output logic [2:0]  digitos,
    output logic        error_tecla,
    output logic        timeout_clave
);

    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    // The counter is compared one short of the limit so the pulse lands
    // exactly TIMEOUT_CICLOS edges after the last accepted key.
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        CAPTURA = 2'd1,
        BLOQUEO = 2'd2
    } estado_t;

    estado_t estado;
    estado_t estado_sig;

    logic          tecla_prev;
    logic          tecla_aceptada;
    logic          activa;

    logic [15:0]   buffer;
    logic [15:0]   buffer_sig;
    logic [2:0]    digitos_sig;
    logic [15:0]   clave_sig;
    logic          lista_sig;
    logic          error_sig;
    logic          timeout_sig;
    logic [CW-1:0] cuenta;
    logic [CW-1:0] cuenta_sig;

    assign tecla_aceptada = tecla_valida & ~tecla_prev;

    // Keys act only when the FSM is already in CAPTURA and no higher-priority
    // transition is pending on this edge; this is also what makes a key on
    // the very edge the vehicle arrives get ignored.
    assign activa = (estado == CAPTURA) && !alarm_bloqueo && llegado_vehiculo;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic
    always_comb begin
        estado_sig = estado;
        if (alarm_bloqueo) begin
            estado_sig = BLOQUEO;
        end else begin
            case (estado)
                BLOQUEO: estado_sig = llegado_vehiculo ? CAPTURA : ESPERA;
                CAPTURA: estado_sig = llegado_vehiculo ? CAPTURA : ESPERA;
                ESPERA:  estado_sig = llegado_vehiculo ? CAPTURA : ESPERA;
                default: estado_sig = ESPERA;
            endcase
        end
    end

    // Output / datapath logic: next values of every registered output
    always_comb begin
        buffer_sig  = buffer;
        digitos_sig = digitos;
        clave_sig   = clave_ingresada;
        lista_sig   = 1'b0;
        error_sig   = 1'b0;
        timeout_sig = 1'b0;
        cuenta_sig  = '0;

        if (!activa) begin
            buffer_sig  = 16'h0000;
            digitos_sig = 3'd0;
        end else if (tecla_aceptada) begin
            // Any accepted key, rejected or not, restarts the idle count.
            if (tecla <= 4'h9) begin
                if (digitos < 3'd4) begin
                    buffer_sig  = {buffer[11:0], tecla};
                    digitos_sig = digitos + 3'd1;
                end else begin
                    error_sig = 1'b1;
                end
            end else if (tecla == 4'hE) begin
                if (digitos != 3'd0) begin
                    buffer_sig  = buffer >> 4;
                    digitos_sig = digitos - 3'd1;
                end
            end else if (tecla == 4'hF) begin
                if (digitos == 3'd4) begin
                    clave_sig   = buffer;
                    lista_sig   = 1'b1;
                    buffer_sig  = 16'h0000;
                    digitos_sig = 3'd0;
                end else begin
                    error_sig = 1'b1;
                end
            end else begin
                error_sig = 1'b1;
            end
        end else if (digitos != 3'd0) begin
            if (cuenta == LIMITE) begin
                buffer_sig  = 16'h0000;
                digitos_sig = 3'd0;
                timeout_sig = 1'b1;
            end else begin
                cuenta_sig = cuenta + 1'b1;
            end
        end
    end

    // Registered outputs and datapath state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tecla_prev      <= 1'b0;
            buffer          <= 16'h0000;
            digitos         <= 3'd0;
            clave_ingresada <= 16'h0000;
            clave_lista     <= 1'b0;
            error_tecla     <= 1'b0;
            timeout_clave   <= 1'b0;
            cuenta          <= '0;
        end else begin
            tecla_prev      <= tecla_valida;
            buffer          <= buffer_sig;
            digitos         <= digitos_sig;
            clave_ingresada <= clave_sig;
            clave_lista     <= lista_sig;
            error_tecla     <= error_sig;
            timeout_clave   <= timeout_sig;
            cuenta          <= cuenta_sig;
        end
    end

endmodule
